// File: rtl/rob_multi.sv
// Multi-port reorder buffer: N_CDB writeback ports, in-order retirement of up to
// COMMIT_W entries per cycle, and precise flush when a mispredicted branch retires.
module rob_multi #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned N_CDB    = 4,
   parameter int unsigned COMMIT_W = 2,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alloc_valid,
   output logic                         alloc_ready,
   input  logic [4:0]                   alloc_rd_addr,
   input  logic                         alloc_regf_we,
   input  logic [DATA_W-1:0]            alloc_pc,
   output logic [IDX_W-1:0]             alloc_idx,
   input  logic [N_CDB-1:0]             cdb_valid,
   input  logic [N_CDB*IDX_W-1:0]       cdb_idx,
   input  logic [N_CDB*DATA_W-1:0]      cdb_data,
   input  logic [N_CDB-1:0]             cdb_mispred,
   input  logic [N_CDB*DATA_W-1:0]      cdb_pc_new,
   output logic [COMMIT_W-1:0]          commit_valid,
   output logic [COMMIT_W*5-1:0]        commit_rd_addr,
   output logic [COMMIT_W*DATA_W-1:0]   commit_data,
   output logic [COMMIT_W-1:0]          commit_we,
   input  logic                         commit_ready,
   output logic                         flush_o,
   output logic [DATA_W-1:0]            flush_pc,
   output logic [IDX_W:0]               count_o
);
   localparam int unsigned RD_W  = 5;
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, mispred_q, mispred_d, we_q, we_d;
   logic [RD_W-1:0]   rd_q     [DEPTH];
   logic [RD_W-1:0]   rd_d     [DEPTH];
   logic [DATA_W-1:0] data_q   [DEPTH];
   logic [DATA_W-1:0] data_d   [DEPTH];
   logic [DATA_W-1:0] pc_new_q [DEPTH];
   logic [DATA_W-1:0] pc_new_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              flush_q, flush_d;
   logic [DATA_W-1:0] flush_pc_q, flush_pc_d;

   logic [COMMIT_W-1:0] offer_c;
   logic [CNT_W-1:0]    n_ret_c;
   logic                mis_grp_c, alloc_fire_c, flush_fire_c, grp_stop;
   logic [DATA_W-1:0]   mis_pc_c;
   logic [IDX_W-1:0]    grp_idx, out_idx, wb_idx, ret_idx;

   // Commit group: contiguous done entries from head, closed after a mispredict
   always_comb begin
      offer_c   = '0;
      n_ret_c   = '0;
      mis_grp_c = 1'b0;
      mis_pc_c  = '0;
      grp_stop  = 1'b0;
      grp_idx   = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         grp_idx = head_q + IDX_W'(k);
         if (!grp_stop && (CNT_W'(k) < count_q) && valid_q[grp_idx] && done_q[grp_idx]) begin
            offer_c[k] = 1'b1;
            n_ret_c    = CNT_W'(k + 1);
            if (mispred_q[grp_idx]) begin
               grp_stop  = 1'b1;
               mis_grp_c = 1'b1;
               mis_pc_c  = pc_new_q[grp_idx];
            end
         end else begin
            grp_stop = 1'b1;
         end
      end
   end

   always_comb begin
      commit_valid   = offer_c;
      commit_rd_addr = '0;
      commit_data    = '0;
      commit_we      = '0;
      out_idx        = '0;
      for (int k = 0; k < COMMIT_W; k++) begin
         out_idx = head_q + IDX_W'(k);
         if (offer_c[k]) begin
            commit_rd_addr[k*RD_W +: RD_W]     = rd_q[out_idx];
            commit_data[k*DATA_W +: DATA_W]    = data_q[out_idx];
            commit_we[k]                       = we_q[out_idx];
         end
      end
   end

   assign alloc_ready  = (count_q < CNT_W'(DEPTH)) && !mis_grp_c;
   assign alloc_idx    = tail_q;
   assign alloc_fire_c = alloc_valid && alloc_ready;
   assign flush_fire_c = commit_ready && mis_grp_c;
   assign flush_o      = flush_q;
   assign flush_pc     = flush_pc_q;
   assign count_o      = count_q;

   // Next state: writeback, allocate, retire, then flush overrides
   always_comb begin
      valid_d    = valid_q;
      done_d     = done_q;
      mispred_d  = mispred_q;
      we_d       = we_q;
      rd_d       = rd_q;
      data_d     = data_q;
      pc_new_d   = pc_new_q;
      head_d     = head_q;
      tail_d     = tail_q;
      flush_d    = flush_fire_c;
      flush_pc_d = flush_pc_q;
      wb_idx     = '0;
      ret_idx    = '0;
      if (!flush_fire_c) begin
         for (int p = 0; p < N_CDB; p++) begin
            wb_idx = cdb_idx[p*IDX_W +: IDX_W];
            if (cdb_valid[p] && valid_q[wb_idx] && !done_q[wb_idx]) begin
               done_d[wb_idx]    = 1'b1;
               data_d[wb_idx]    = cdb_data[p*DATA_W +: DATA_W];
               mispred_d[wb_idx] = cdb_mispred[p];
               pc_new_d[wb_idx]  = cdb_pc_new[p*DATA_W +: DATA_W];
            end
         end
      end
      // pc_new holds the entry's own pc until writeback supplies the target
      if (alloc_fire_c) begin
         valid_d[tail_q]   = 1'b1;
         done_d[tail_q]    = 1'b0;
         mispred_d[tail_q] = 1'b0;
         we_d[tail_q]      = alloc_regf_we;
         rd_d[tail_q]      = alloc_rd_addr;
         pc_new_d[tail_q]  = alloc_pc;
         tail_d            = tail_q + IDX_W'(1);
      end
      if (commit_ready) begin
         for (int k = 0; k < COMMIT_W; k++) begin
            ret_idx = head_q + IDX_W'(k);
            if (offer_c[k]) begin
               valid_d[ret_idx]   = 1'b0;
               done_d[ret_idx]    = 1'b0;
               mispred_d[ret_idx] = 1'b0;
            end
         end
         head_d = head_q + IDX_W'(n_ret_c);
      end
      count_d = count_q + CNT_W'(alloc_fire_c) - (commit_ready ? n_ret_c : CNT_W'(0));
      if (flush_fire_c) begin
         valid_d    = '0;
         done_d     = '0;
         mispred_d  = '0;
         tail_d     = head_d;
         count_d    = '0;
         flush_pc_d = mis_pc_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= '0;
         done_q     <= '0;
         mispred_q  <= '0;
         we_q       <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]     <= '0;
            data_q[i]   <= '0;
            pc_new_q[i] <= '0;
         end
      end else begin
         valid_q    <= valid_d;
         done_q     <= done_d;
         mispred_q  <= mispred_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         pc_new_q   <= pc_new_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         flush_q    <= flush_d;
         flush_pc_q <= flush_pc_d;
      end
   end
endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
- Parametrised reorder buffer, successor to the single-port ROB; sits between dispatch, the CDB and the commit stage.
- Generalised in three ways:
  - configurable depth;
  - N_CDB independent writeback ports;
  - in-order retirement of up to COMMIT_W entries per cycle.
- Owns precise misprediction recovery: flush is raised only when a mispredicted branch retires, and all younger entries are squashed in the same edge.

Parameters:
DEPTH, 16, entry count; power of two, >= 4
N_CDB, 4, number of CDB writeback ports
COMMIT_W, 2, max entries retired per cycle, 1..4
DATA_W, 32, result/PC width
IDX_W, $clog2(DEPTH), ROB index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
alloc_valid  in  1  dispatch requests one entry
alloc_ready  out  1  entry can be accepted this cycle
alloc_rd_addr  in  5  architectural destination
alloc_regf_we  in  1  entry writes the register file
alloc_pc  in  DATA_W  instruction PC
alloc_idx  out  IDX_W  index granted (= tail)
cdb_valid  in  N_CDB  per-port writeback strobe
cdb_idx  in  N_CDB*IDX_W  target ROB index per port
cdb_data  in  N_CDB*DATA_W  result per port
cdb_mispred  in  N_CDB  port reports a mispredicted branch
cdb_pc_new  in  N_CDB*DATA_W  correct target per port
commit_valid  out  COMMIT_W  slot k retires this cycle (thermometer, slot 0 = head)
commit_rd_addr  out  COMMIT_W*5  per slot
commit_data  out  COMMIT_W*DATA_W  per slot
commit_we  out  COMMIT_W  per slot regf_we
commit_ready  in  1  commit stage accepts all offered slots
flush_o  out  1  one-cycle recovery pulse
flush_pc  out  DATA_W  redirect target, valid with flush_o
count_o  out  IDX_W+1  occupied entries

Behaviour:
- Reset:
  - Applies on rst low, asynchronously.
  - Clears head, tail, count, all entry valid/done/mispred bits, flush_o and flush_pc.
  - All outputs read 0, except alloc_ready = 1 and alloc_idx = 0.
- Entry state: valid, done, mispred, rd_addr, regf_we, pc, data, pc_new.
- Allocation:
  - alloc_ready = (count < DEPTH) && !mispred_in_group.
  - alloc_ready never depends on commit_ready (no comb loop).
  - A handshake at the edge writes tail with valid=1, done=0, then tail+1 mod DEPTH.
  - alloc_idx = tail, combinational.
- Writeback:
  - On cdb_valid[p], the edge sets done=1 and stores data, mispred and pc_new, only if entry cdb_idx[p] is valid and not done; otherwise the write is ignored.
  - If several ports target the same index in one cycle, the highest p wins.
- Commit group (combinational from registered state):
  - Slot k (k < COMMIT_W, k < count) is offered when entries head..head+k are all valid and done.
  - The group stops after the first entry with mispred=1.
  - mispred_in_group = an offered slot carries mispred.
- Retire (edge with commit_ready = 1 and n offered slots):
  - head += n mod DEPTH; offered entries are cleared.
  - With commit_ready = 0, nothing retires and outputs hold.
- Flush:
  - If the retiring group contains a mispredicted entry: every younger entry is invalidated, tail <= new head, count <= 0, and all CDB writes on that edge are ignored.
  - Next cycle: flush_o = 1 for exactly one cycle, flush_pc = that entry's pc_new.
- Count:
  - Normal edge: count_next = count + alloc_fire - n.
  - Flush edge: count_next = 0.
  - Simultaneous alloc and retire when full: alloc_ready = 0 (conservative), retire proceeds.
- Wrap-around: all pointer and index arithmetic is mod DEPTH; a commit group may span the DEPTH-1 -> 0 boundary.
- Reset mid-flush or mid-group: state returns to reset values immediately; no flush_o pulse follows.

Test Plan:
1. Reset, allocate 16 entries with DEPTH=16 -> alloc_idx 0..15, count_o=16, alloc_ready=0 after the 16th edge.
2. Complete entries out of order (CDB idx 3,1,0,2) with commit_ready=1 -> retires {0,1} in one cycle, then {2,3}; commit_data matches CDB values in order.
3. Two ports write idx 5 in one cycle (data 0xA, 0xB on ports 1 and 3) -> entry 5 data = 0xB.
4. Head at 14, entries 14, 15, 0 done -> group = {14,15}, next cycle {0}; head wraps to 1.
5. Entry 2 done with mispred, pc_new=0x1000, entries 3..7 valid -> retire through 2; next cycle flush_o=1 for one cycle, flush_pc=0x1000, count_o=0; a late CDB write to idx 4 is ignored.
6. Assert rst low during step 5's flush edge -> count_o=0, flush_o stays 0, alloc_idx=0.
